// File: rtl/neuron_mac_seq_if.sv
// Handshake/operand bus between the neuron register block, the operand RAM and neuron_mac_seq.
// The sequencer connects through the slave modport; whoever drives start/count/bias and the RAM data uses master.
interface neuron_mac_seq_if #(
    parameter int N_MAX  = 16,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = $clog2(N_MAX)
) ();
    logic              start;
    logic [ADDR_W:0]   count;
    logic [ACC_W-1:0]  bias;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_x;
    logic [DATA_W-1:0] mem_w;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  result;
    logic              ovf;

    modport slave (
        input  start, count, bias, mem_x, mem_w,
        output mem_rd, mem_addr, busy, done, result, ovf
    );

    modport master (
        output start, count, bias, mem_x, mem_w,
        input  mem_rd, mem_addr, busy, done, result, ovf
    );
endinterface

// File: rtl/neuron_mac_seq.sv
// Single-neuron MAC sequencer: bias + saturating sum of x*w over a one-cycle-latency operand RAM.
// Define NEURON_MAC_SEQ_RELU_EN to apply ReLU to the result (ovf still reports pre-activation saturation).
module neuron_mac_seq #(
    parameter int N_MAX  = 16,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = $clog2(N_MAX)
) (
    input logic             ACLK,
    input logic             ARESETN,
    neuron_mac_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

    localparam logic [ADDR_W:0]  N_MAX_C = (ADDR_W+1)'(N_MAX);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              rd_dly_q, rd_dly_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic              ovf_q, ovf_d;

    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W:0]             sum;
    logic                       sat_ovf;
    logic [ACC_W-1:0]           sat_val;
    logic [ACC_W-1:0]           act_val;
    logic [ADDR_W:0]            n_start;

    // One guard bit above the accumulator exposes signed overflow of the add.
    assign prod    = $signed({{DATA_W{bus.mem_x[DATA_W-1]}}, bus.mem_x})
                   * $signed({{DATA_W{bus.mem_w[DATA_W-1]}}, bus.mem_w});
    assign sum     = {acc_q[ACC_W-1], acc_q}
                   + {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign sat_ovf = sum[ACC_W] ^ sum[ACC_W-1];
    assign sat_val = sat_ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
    assign n_start = (bus.count > N_MAX_C) ? N_MAX_C : bus.count;

`ifdef NEURON_MAC_SEQ_RELU_EN
    assign act_val = acc_q[ACC_W-1] ? '0 : acc_q;
`else
    assign act_val = acc_q;
`endif

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        acc_d      = acc_q;
        rd_dly_d   = mem_rd_q;
        mem_rd_d   = mem_rd_q;
        mem_addr_d = mem_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        ovf_d      = ovf_q;

        // RAM data returned for last cycle's read is folded in now.
        if (rd_dly_q) begin
            acc_d = sat_val;
            if (sat_ovf) ovf_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    n_d        = n_start;
                    acc_d      = bus.bias;
                    ovf_d      = 1'b0;
                    mem_addr_d = '0;
                    busy_d     = 1'b1;
                    if (n_start != '0) begin
                        mem_rd_d = 1'b1;
                        state_d  = FETCH;
                    end else begin
                        state_d  = FIN;
                    end
                end
            end
            FETCH: begin
                if ({1'b0, mem_addr_q} == n_q - (ADDR_W+1)'(1)) begin
                    mem_rd_d = 1'b0;
                    state_d  = DRAIN;
                end else begin
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                end
            end
            DRAIN: state_d = FIN;
            FIN: begin
                result_d = act_val;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= IDLE;
            n_q        <= '0;
            acc_q      <= '0;
            rd_dly_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            acc_q      <= acc_d;
            rd_dly_q   <= rd_dly_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_neuron_mac_seq.sv
// Randomized self-checking bench for neuron_mac_seq against a plain-arithmetic neuron model.
module tb_neuron_mac_seq;
    logic clk;
    logic rst_n;

    neuron_mac_seq_if #(.N_MAX(16), .DATA_W(16), .ACC_W(32)) bus ();

    neuron_mac_seq #(.N_MAX(16), .DATA_W(16), .ACC_W(32)) dut (
        .ACLK    (clk),
        .ARESETN (rst_n),
        .bus     (bus)
    );

    logic [15:0] xs [16];
    logic [15:0] ws [16];
    int          rd_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // Operand RAM: one-cycle registered read, every read address logged.
    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.mem_x <= xs[bus.mem_addr];
            bus.mem_w <= ws[bus.mem_addr];
            rd_q.push_back(int'(bus.mem_addr));
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [31:0] b, input int cnt,
                                  output logic [31:0] res, output bit ov);
        longint acc;
        longint maxv;
        longint minv;
        int     n;
        maxv = 64'sd2147483647;
        minv = -64'sd2147483648;
        n    = (cnt > 16) ? 16 : cnt;
        acc  = longint'(signed'(b));
        ov   = 1'b0;
        for (int i = 0; i < n; i++) begin
            acc = acc + longint'(signed'(xs[i])) * longint'(signed'(ws[i]));
            if (acc > maxv) begin acc = maxv; ov = 1'b1; end
            else if (acc < minv) begin acc = minv; ov = 1'b1; end
        end
`ifdef NEURON_MAC_SEQ_RELU_EN
        if (acc < 0) acc = 0;
`endif
        res = acc[31:0];
    endfunction

    // lat counts rising edges from the start-sampling edge up to the visible done.
    task automatic wait_done(input bit mid_start, input bit hold, output int lat, output bit seen);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 64) begin
            if (bus.done) seen = 1'b1;
            else begin
                if (mid_start && lat == 4) begin
                    bus.start = 1'b1;
                    bus.count = 5'd3;
                    bus.bias  = 32'h0;
                end else if (!hold) begin
                    bus.start = 1'b0;
                end
                @(negedge clk);
                lat++;
            end
        end
    endtask

    task automatic finish_run(input logic [31:0] b, input int cnt, input logic [31:0] er,
                              input bit eo, input int lat, input bit seen);
        int n;
        n = (cnt > 16) ? 16 : cnt;
        check("done_seen", 64'(seen), 64'd1);
        check("latency", 64'(lat), (n == 0) ? 64'd2 : 64'(n + 3));
        check("result", 64'(bus.result), 64'(er));
        check("ovf", 64'(bus.ovf), 64'(eo));
        check("busy_clr", 64'(bus.busy), 64'd0);
        check("read_count", 64'(rd_q.size()), 64'(n));
        for (int i = 0; i < n && i < rd_q.size(); i++)
            check("read_addr", 64'(rd_q[i]), 64'(i));
        $display("run bias=%08h count=%0d result=%08h ovf=%0b lat=%0d", b, cnt, bus.result, bus.ovf, lat);
    endtask

    task automatic run(input logic [31:0] b, input int cnt, input bit mid_start);
        logic [31:0] er;
        bit          eo;
        int          lat;
        bit          seen;
        model(b, cnt, er, eo);
        @(negedge clk);
        bus.start = 1'b1;
        bus.count = 5'(cnt);
        bus.bias  = b;
        rd_q.delete();
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_set", 64'(bus.busy), 64'd1);
        wait_done(mid_start, 1'b0, lat, seen);
        finish_run(b, cnt, er, eo, lat, seen);
        @(negedge clk);
        check("done_pulse", 64'(bus.done), 64'd0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_mem_rd"}, 64'(bus.mem_rd), 64'd0);
        check({tag, "_addr"}, 64'(bus.mem_addr), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_result"}, 64'(bus.result), 64'd0);
        check({tag, "_ovf"}, 64'(bus.ovf), 64'd0);
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 16; i++) begin
            xs[i] = 16'($urandom);
            ws[i] = 16'($urandom);
        end
    endtask

    initial begin
        logic [31:0] er;
        logic [31:0] er_b;
        bit          eo;
        bit          eo_b;
        int          lat;
        bit          seen;
        int          dn;

        clk       = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.count = '0;
        bus.bias  = '0;
        for (int i = 0; i < 16; i++) begin xs[i] = '0; ws[i] = '0; end

        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;

        // Directed: dot product of {1,2,3,4} and {5,6,7,8}
        for (int i = 0; i < 4; i++) begin
            xs[i] = 16'(i + 1);
            ws[i] = 16'(i + 5);
        end
        run(32'd0, 4, 1'b0);

        xs[0] = 16'd3;
        ws[0] = 16'hFFFC;
        run(32'hFFFF_FF9C, 1, 1'b0);

        run(32'd42, 0, 1'b0);

        xs[0] = 16'h7FFF; ws[0] = 16'h7FFF;
        xs[1] = 16'h7FFF; ws[1] = 16'h7FFF;
        run(32'h7FFF_0000, 2, 1'b0);
        xs[0] = 16'd1; ws[0] = 16'd1;
        run(32'h7FFF_0000, 1, 1'b0);

        // Oversized count clamps, and a stray start mid-run is ignored
        randomize_mem();
        run(32'($urandom_range(0, 1000)), 20, 1'b1);

        // Async reset mid-run aborts without a done
        @(negedge clk);
        bus.start = 1'b1;
        bus.count = 5'd8;
        bus.bias  = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_zero("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("abort_no_done", 64'(dn), 64'd0);
        run(32'd5, 3, 1'b0);

        // Back-to-back: start held through done launches the second run at once
        randomize_mem();
        model(32'd100, 5, er, eo);
        model(32'hFFFF_F000, 2, er_b, eo_b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.count = 5'd5;
        bus.bias  = 32'd100;
        rd_q.delete();
        @(negedge clk);
        bus.count = 5'd2;
        bus.bias  = 32'hFFFF_F000;
        wait_done(1'b0, 1'b1, lat, seen);
        finish_run(32'd100, 5, er, eo, lat, seen);
        rd_q.delete();
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy", 64'(bus.busy), 64'd1);
        check("b2b_done_low", 64'(bus.done), 64'd0);
        wait_done(1'b0, 1'b0, lat, seen);
        finish_run(32'hFFFF_F000, 2, er_b, eo_b, lat, seen);

        // Random runs, large biases to provoke saturation in both directions
        for (int t = 0; t < 20; t++) begin
            randomize_mem();
            if (t % 3 == 0) run(32'($urandom), $urandom_range(0, 20), 1'b0);
            else run(32'($signed($urandom_range(0, 2000)) - 1000), $urandom_range(0, 20), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
